// File: rtl/game_dialog_ctrl_if.sv
// Bundle of frame/zone/key inputs and overlay/flag outputs shared between
// the game pipeline (master) and the dialog sequencer (slave).
interface game_dialog_ctrl_if;
  logic       frame_tick;
  logic [3:0] current_pix;
  logic [3:0] key;
  logic [2:0] dialog_sel;
  logic [1:0] page;
  logic       dialog_active;
  logic       item;
  logic       item2;
  logic       door;

  modport master (
    output frame_tick, current_pix, key,
    input  dialog_sel, page, dialog_active, item, item2, door
  );

  modport slave (
    input  frame_tick, current_pix, key,
    output dialog_sel, page, dialog_active, item, item2, door
  );
endinterface

// File: rtl/game_dialog_ctrl.sv
// Dialog overlay sequencer: debounces zone entry on frame ticks, pages through
// dialogs, applies the quest-progress flag rules and enforces a close cooldown.
module game_dialog_ctrl #(
  parameter logic [3:0] ENTER_FRAMES = 4'd2,
  parameter logic [3:0] CLOSE_FRAMES = 4'd4,
  parameter logic [1:0] LAST_PAGE    = 2'd3,
  parameter logic [3:0] KEY_ACCEPT   = 4'h1,
  parameter logic [3:0] KEY_NEXT     = 4'h2
) (
  input logic                clk,
  input logic                rst,
  game_dialog_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARM, SHOW, CLOSE} state_t;

  state_t     state_q, state_d;
  logic [3:0] zone_q, zone_d;
  logic [3:0] deb_q, deb_d;
  logic [3:0] cool_q, cool_d;
  logic       dismissed_q, dismissed_d;
  logic [3:0] key_q;
  logic [2:0] sel_q, sel_d;
  logic [1:0] page_q, page_d;
  logic       active_q, active_d;
  logic       item_q, item_d;
  logic       item2_q, item2_d;
  logic       door_q, door_d;

  logic [2:0] zsel;
  logic       pressAccept;
  logic       pressNext;
  logic [3:0] debNext;
  logic [3:0] coolNext;

  // Dialog a zone would show given the flags as they stand this cycle.
  always_comb begin
    zsel = 3'd0;
    unique case (bus.current_pix)
      4'd2:    zsel = 3'd1;
      4'd3:    zsel = item_q ? 3'd3 : 3'd2;
      4'd4:    zsel = door_q ? 3'd6 : 3'd4;
      4'd6:    zsel = 3'd5;
      default: zsel = 3'd0;
    endcase
  end

  assign pressAccept = (bus.key == KEY_ACCEPT) && (key_q != KEY_ACCEPT);
  assign pressNext   = (bus.key == KEY_NEXT)   && (key_q != KEY_NEXT);

  assign debNext  = (bus.frame_tick && deb_q  != 4'hF) ? deb_q  + 4'd1 : deb_q;
  assign coolNext = (bus.frame_tick && cool_q != 4'hF) ? cool_q + 4'd1 : cool_q;

  always_comb begin
    state_d     = state_q;
    zone_d      = zone_q;
    deb_d       = deb_q;
    cool_d      = cool_q;
    dismissed_d = dismissed_q;
    sel_d       = sel_q;
    page_d      = page_q;
    active_d    = active_q;
    item_d      = item_q;
    item2_d     = item2_q;
    door_d      = door_q;

    unique case (state_q)
      IDLE: begin
        if (zsel == 3'd0) begin
          dismissed_d = 1'b0;
        end else if (!dismissed_q) begin
          state_d = ARM;
          zone_d  = bus.current_pix;
          deb_d   = 4'd0;
        end
      end

      ARM: begin
        if (bus.current_pix != zone_q) begin
          if (zsel != 3'd0) begin
            zone_d = bus.current_pix;
            deb_d  = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          deb_d = debNext;
          if (debNext >= ENTER_FRAMES) begin
            state_d  = SHOW;
            sel_d    = zsel;
            page_d   = 2'd0;
            active_d = 1'b1;
          end
        end
      end

      // A dialog_sel switch (flag just changed) takes the cycle; presses then are dropped.
      SHOW: begin
        if (bus.current_pix != zone_q) begin
          state_d  = CLOSE;
          active_d = 1'b0;
          sel_d    = 3'd0;
          page_d   = 2'd0;
          cool_d   = 4'd0;
        end else if (zsel != sel_q) begin
          sel_d  = zsel;
          page_d = 2'd0;
        end else if (pressNext) begin
          if (page_q < LAST_PAGE) begin
            page_d = page_q + 2'd1;
          end else begin
            state_d     = CLOSE;
            active_d    = 1'b0;
            sel_d       = 3'd0;
            page_d      = 2'd0;
            cool_d      = 4'd0;
            dismissed_d = 1'b1;
          end
        end else if (pressAccept) begin
          unique case (sel_q)
            3'd2:    item_d = 1'b1;
            3'd4:    if (item_q) door_d = 1'b1;
            3'd5:    if (item_q) item2_d = 1'b1;
            default: ;
          endcase
        end
      end

      CLOSE: begin
        if (zsel == 3'd0) dismissed_d = 1'b0;
        cool_d = coolNext;
        if (coolNext >= CLOSE_FRAMES) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      zone_q      <= 4'd0;
      deb_q       <= 4'd0;
      cool_q      <= 4'd0;
      dismissed_q <= 1'b0;
      key_q       <= 4'd0;
      sel_q       <= 3'd0;
      page_q      <= 2'd0;
      active_q    <= 1'b0;
      item_q      <= 1'b0;
      item2_q     <= 1'b0;
      door_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      deb_q       <= deb_d;
      cool_q      <= cool_d;
      dismissed_q <= dismissed_d;
      key_q       <= bus.key;
      sel_q       <= sel_d;
      page_q      <= page_d;
      active_q    <= active_d;
      item_q      <= item_d;
      item2_q     <= item2_d;
      door_q      <= door_d;
    end
  end

  assign bus.dialog_sel    = sel_q;
  assign bus.page          = page_q;
  assign bus.dialog_active = active_q;
  assign bus.item          = item_q;
  assign bus.item2         = item2_q;
  assign bus.door          = door_q;

endmodule
